sipo_deframer: RTL and testbench

- Serial-to-parallel receive stage that sits directly downstream of the 16-bit PISO serializer.
- Samples the serial bit stream on qualified clock edges and uses a frame-sync marker to align word boundaries.
- Reassembles WIDTH-bit words and presents each word with a one-cycle valid strobe.
- Flags framing violations, so a PISO→deframer loopback checks itself end to end.

---
 rtl/sipo_deframer.sv | 111 +++++++++++
 tb/tb_sipo_deframer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: sync-aligned WIDTH-bit word assembly with framing checks.
// Define SIPO_DEFRAMER_PARITY_EN to expect a trailing even-parity bit after each word.
module sipo_deframer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIPO_DEFRAMER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;

  // New bits enter at the end that makes the first bit finish in the chosen dout position.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
    if (MSB_FIRST) return {s[WIDTH-2:0], b};
    else           return {b, s[WIDTH-1:1]};
  endfunction

  assign busy = (state != IDLE);

`ifndef SIPO_DEFRAMER_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SIPO_DEFRAMER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (din_en) begin
        case (state)
          IDLE: begin
            if (sync) begin
              sreg  <= shift_in('0, din);
              cnt   <= CW'(1);
              state <= SHIFT;
            end
          end
          SHIFT: begin
            if (sync) begin
              frame_err <= 1'b1;
              sreg      <= shift_in('0, din);
              cnt       <= CW'(1);
            end else if (cnt == LAST) begin
`ifdef SIPO_DEFRAMER_PARITY_EN
              sreg  <= shift_in(sreg, din);
              cnt   <= CW'(WIDTH);
              state <= PAR;
`else
              dout       <= shift_in(sreg, din);
              dout_valid <= 1'b1;
              cnt        <= '0;
              state      <= IDLE;
`endif
            end else begin
              sreg <= shift_in(sreg, din);
              cnt  <= cnt + CW'(1);
            end
          end
`ifdef SIPO_DEFRAMER_PARITY_EN
          // The full word is already in sreg; this edge carries only the parity bit.
          PAR: begin
            if (sync) begin
              frame_err <= 1'b1;
              sreg      <= shift_in('0, din);
              cnt       <= CW'(1);
              state     <= SHIFT;
            end else begin
              dout       <= sreg;
              dout_valid <= 1'b1;
              parity_err <= (^sreg) ^ din;
              cnt        <= '0;
              state      <= IDLE;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: MSB-first and LSB-first instances on one shared stream,
// checked every cycle against a queue-based frame model plus directed scenario checks.
module tb_sipo_deframer;

  localparam int WIDTH = 16;
`ifdef SIPO_DEFRAMER_PARITY_EN
  localparam int FRAME  = WIDTH + 1;
  localparam bit PAR_ON = 1'b1;
`else
  localparam int FRAME  = WIDTH;
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, din, din_en, sync;
  logic [WIDTH-1:0] dout_m, dout_l;
  logic v_m, v_l, b_m, b_l, fe_m, fe_l, pe_m, pe_l;

  always #5 clk = ~clk;

  sipo_deframer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .sync(sync),
    .dout(dout_m), .dout_valid(v_m), .busy(b_m), .frame_err(fe_m), .parity_err(pe_m)
  );

  sipo_deframer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .sync(sync),
    .dout(dout_l), .dout_valid(v_l), .busy(b_l), .frame_err(fe_l), .parity_err(pe_l)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int last_valid = -1;
  int valid_gap = 0;
  int valid_count = 0;

  // Reference model: bits of the frame in arrival order, plus expected outputs.
  bit               q[$];
  bit               active;
  logic [WIDTH-1:0] exp_m, exp_l;
  logic             exp_valid, exp_ferr, exp_perr;

  task automatic modelReset();
    q.delete();
    active    = 1'b0;
    exp_m     = '0;
    exp_l     = '0;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    exp_perr  = 1'b0;
  endtask

  task automatic modelEdge();
    bit p;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    if (din_en === 1'b1) begin
      if (sync === 1'b1) begin
        if (active) exp_ferr = 1'b1;
        q.delete();
        q.push_back(din);
        active = 1'b1;
      end else if (active) begin
        q.push_back(din);
      end
      if (active && q.size() == FRAME) begin
        p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          exp_m[WIDTH-1-i] = q[i];
          exp_l[i]         = q[i];
          p                = p ^ q[i];
        end
        if (PAR_ON) exp_perr = p ^ q[FRAME-1];
        exp_valid = 1'b1;
        active    = 1'b0;
        q.delete();
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compareAll();
    checkOutput("dout_msb", 64'(dout_m), 64'(exp_m));
    checkOutput("dout_lsb", 64'(dout_l), 64'(exp_l));
    checkOutput("valid_msb", 64'(v_m), 64'(exp_valid));
    checkOutput("valid_lsb", 64'(v_l), 64'(exp_valid));
    checkOutput("busy_msb", 64'(b_m), 64'(active));
    checkOutput("busy_lsb", 64'(b_l), 64'(active));
    checkOutput("ferr_msb", 64'(fe_m), 64'(exp_ferr));
    checkOutput("ferr_lsb", 64'(fe_l), 64'(exp_ferr));
    checkOutput("perr_msb", 64'(pe_m), 64'(exp_perr));
    checkOutput("perr_lsb", 64'(pe_l), 64'(exp_perr));
  endtask

  task automatic applyStimulus(input logic d, input logic en, input logic s);
    din    = d;
    din_en = en;
    sync   = s;
    @(posedge clk);
    modelEdge();
    cycle++;
    #1;
    compareAll();
    if (v_m === 1'b1) begin
      if (last_valid >= 0) valid_gap = cycle - last_valid;
      last_valid = cycle;
      valid_count++;
    end
  endtask

  // Sends bits [from..WIDTH-1] of w (sync on bit 0), idle gaps between bits, then parity if built in.
  task automatic sendBits(input logic [WIDTH-1:0] w, input bit msb_order, input int from,
                          input int gap, input bit bad_par);
    logic b;
    for (int i = from; i < WIDTH; i++) begin
      b = msb_order ? w[WIDTH-1-i] : w[i];
      applyStimulus(b, 1'b1, i == 0);
      if (i < WIDTH - 1 || PAR_ON)
        for (int g = 0; g < gap; g++) applyStimulus(1'($urandom), 1'b0, 1'($urandom));
    end
    if (PAR_ON) applyStimulus((^w) ^ bad_par, 1'b1, 1'b0);
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] w, input bit msb_order, input int gap);
    sendBits(w, msb_order, 0, gap, 1'b0);
  endtask

  int vc0;
  logic [WIDTH-1:0] rw;

  initial begin
    rst = 1'b1; din = 1'b0; din_en = 1'b0; sync = 1'b0;
    modelReset();
    #12;
    compareAll();
    rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    // Basic MSB-first word
    sendWord(16'hA5C3, 1'b1, 0);
    checkOutput("basic_dout", 64'(dout_m), 64'h A5C3);
    checkOutput("basic_valid", 64'(v_m), 64'h1);
    checkOutput("basic_busy", 64'(b_m), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("basic_valid_once", 64'(v_m), 64'h0);

    // LSB-first with three idle cycles between bits
    vc0 = valid_count;
    sendWord(16'h1234, 1'b0, 3);
    checkOutput("gap_dout_lsb", 64'(dout_l), 64'h1234);
    checkOutput("gap_one_pulse", 64'(valid_count - vc0), 64'h1);

    // Resync after 7 bits
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, i == 0);
    vc0 = valid_count;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("resync_ferr", 64'(fe_m), 64'h1);
    sendBits(16'h00F0, 1'b1, 1, 0, 1'b0);
    checkOutput("resync_dout", 64'(dout_m), 64'h00F0);
    checkOutput("resync_one_pulse", 64'(valid_count - vc0), 64'h1);

    // Back-to-back frames, second sync in the valid cycle
    sendWord(16'h0001, 1'b1, 0);
    checkOutput("b2b_first", 64'(dout_m), 64'h0001);
    sendWord(16'hFFFF, 1'b1, 0);
    checkOutput("b2b_second", 64'(dout_m), 64'hFFFF);
    checkOutput("b2b_spacing", 64'(valid_gap), 64'(FRAME));

    // Bits without a sync from IDLE are dropped
    vc0 = valid_count;
    for (int i = 0; i < 2 * WIDTH; i++) applyStimulus(1'($urandom), 1'b1, 1'b0);
    checkOutput("nosync_no_valid", 64'(valid_count - vc0), 64'h0);
    checkOutput("nosync_busy", 64'(b_m), 64'h0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 9; i++) applyStimulus(1'($urandom), 1'b1, i == 0);
    #1 rst = 1'b1;
    #1;
    modelReset();
    compareAll();
    checkOutput("rst_dout", 64'(dout_m), 64'h0);
    #2 rst = 1'b0;
    sendWord(16'hBEEF, 1'b1, 0);
    checkOutput("post_rst_dout", 64'(dout_m), 64'hBEEF);

`ifdef SIPO_DEFRAMER_PARITY_EN
    sendBits(16'h0003, 1'b1, 0, 0, 1'b0);
    checkOutput("par_ok", 64'(pe_m), 64'h0);
    checkOutput("par_ok_valid", 64'(v_m), 64'h1);
    sendBits(16'h0007, 1'b1, 0, 0, 1'b1);
    checkOutput("par_bad", 64'(pe_m), 64'h1);
    checkOutput("par_bad_valid", 64'(v_m), 64'h1);
`else
    checkOutput("perr_tied", 64'(pe_m | pe_l), 64'h0);
`endif

    // Random complete frames with random gaps and occasional parity faults
    for (int f = 0; f < 12; f++) begin
      rw = WIDTH'($urandom);
      sendBits(rw, 1'($urandom), 0, int'($urandom_range(2, 0)), 1'($urandom));
    end

    // Fully random stream
    for (int i = 0; i < 600; i++)
      applyStimulus(1'($urandom), ($urandom % 4) != 0, ($urandom % 12) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
